// File: rtl/tdc_multi_capture.sv
// tdc_multi_capture
// Multi-channel time-to-digital capture core. One shared coarse counter runs
// while a measurement is active. Each channel synchronises its asynchronous
// stop input and, on the first rising edge, stores {coarse, fine}. The fine
// code is the popcount of that channel's delay-line thermometer taps.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous reset, active-high
//   start     single-cycle start / re-arm pulse (ignored while running)
//   stop      per-channel asynchronous stop levels
//   taps      per-channel thermometer taps, channel c at [c*N_DELAY +: N_DELAY]
//   ch_sel    readout channel select
//   byte_sel  readout byte select within the 32-bit result
//   dout      registered result byte
//   busy      measurement running
//   done      per-channel captured flags
//   timeout   last run ended on counter saturation
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | counter running, channels armed
// DONE  | all captured or saturated, results held
module tdc_multi_capture #(
  parameter  int N_CH    = 2,
  parameter  int N_DELAY = 32,
  parameter  int CNT_W   = 16,
  localparam int FINE_W  = $clog2(N_DELAY + 1),
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N_CH-1:0]           stop,
  input  logic [N_CH*N_DELAY-1:0]   taps,
  input  logic [SEL_W-1:0]          ch_sel,
  input  logic [1:0]                byte_sel,
  output logic [7:0]                dout,
  output logic                      busy,
  output logic [N_CH-1:0]           done,
  output logic                      timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [N_CH-1:0][31:0]        res_q, res_d;
  logic [N_CH-1:0]              done_q, done_d;
  logic                         timeout_q, timeout_d;
  logic [7:0]                   dout_q, dout_d;

  logic [N_CH-1:0]              s1_q, s2_q, s3_q, edge_q;
  logic [N_CH*N_DELAY-1:0]      t1_q, t2_q;

  logic [N_CH-1:0][FINE_W-1:0]  fine;
  logic [N_CH-1:0]              cap;
  logic [31:0]                  sel_res;

  // Stop synchroniser, history flop and registered edge pulse. The taps
  // pipeline runs alongside so the fine code comes from settled taps.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      edge_q <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
    end else begin
      s1_q   <= stop;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= s2_q & ~s3_q;
      t1_q   <= taps;
      t2_q   <= t1_q;
    end
  end

  // Popcount instead of priority encode: bubbles in the thermometer code
  // still give a sensible fine value.
  always_comb begin
    fine = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int i = 0; i < N_DELAY; i++) begin
        fine[c] = fine[c] + FINE_W'(t2_q[c*N_DELAY + i]);
      end
    end
  end

  assign cap = (state_q == ST_RUN) ? (edge_q & ~done_q) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          res_d     = '0;
          done_d    = '0;
          timeout_d = 1'b0;
        end
      end
      ST_RUN: begin
        for (int c = 0; c < N_CH; c++) begin
          if (cap[c]) begin
            res_d[c]                   = '0;
            res_d[c][FINE_W-1:0]       = fine[c];
            res_d[c][FINE_W +: CNT_W]  = cnt_q;
            done_d[c]                  = 1'b1;
          end
        end
        // Decided on registered flags, so DONE follows the last capture by a cycle.
        if (&done_q) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Unmatched ch_sel (>= N_CH) falls through to zero.
  always_comb begin
    sel_res = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (SEL_W'(c) == ch_sel) sel_res = res_q[c];
    end
    dout_d = 8'(sel_res >> {byte_sel, 3'b000});
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      dout_q    <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: doc/tdc_multi_capture.md
# tdc_multi_capture

Parametrised multi-channel time-to-digital capture core: the next generation of the single-channel TDC readout. It runs one shared coarse cycle counter per measurement and synchronises an asynchronous stop input per channel. At each channel's first stop edge it captures a coarse count plus a fine code, taken as the popcount of that channel's delay-line thermometer taps. Results are read out over an 8-bit byte/channel-selected port, which fits the tiny-tapeout pin budget.

## Interface
- N_CH, 2: number of stop channels (1..8)
- N_DELAY, 32: delay-line taps per channel
- CNT_W, 16: coarse counter width; CNT_W + FINE_W <= 32
- FINE_W (localparam), clog2(N_DELAY+1): fine code width
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-high
- start  in  1  synchronous single-cycle start/re-arm pulse
- stop  in  N_CH  asynchronous stop levels, one per channel
- taps  in  N_CH*N_DELAY  thermometer taps; channel c occupies [c*N_DELAY +: N_DELAY]
- ch_sel  in  clog2(N_CH) (min 1)  readout channel select
- byte_sel  in  2  readout byte select of the 32-bit result
- dout  out  8  selected result byte (registered)
- busy  out  1  high in RUN
- done  out  N_CH  per-channel captured flags
- timeout  out  1  last run ended on counter saturation

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE, start=1 -> RUN next cycle:
  - clear coarse counter, all results, done and timeout.
  - Re-arm all channels; edge-detect history is kept, so a stop already high does not trigger.
- RUN, start=1: ignored.
- Per channel, stop path: 2-FF synchroniser, then a third flop for rising-edge detect.
- Per channel, taps path: a 2-stage register pipeline, so taps stay aligned with the synchronised stop.
- Rising edge on channel c in RUN with done[c]=0:
  - result[c] = {zero pad, coarse, fine}, with coarse = current counter value and fine = popcount(taps stage 2), range 0..N_DELAY.
  - done[c] set.
  - Later edges on c are ignored until re-arm.
- Popcount rather than priority encode, so that bubbles in the thermometer code are tolerated.
- Coarse counter increments by 1 each RUN cycle, starting from 0 in the first RUN cycle.
- RUN -> DONE when all done bits are set, or when the counter equals 2^CNT_W-1.
  - On saturation, set timeout.
  - Uncaptured channels keep result 0 and done 0.
  - A stop edge on that same cycle is still captured, with coarse = all-ones.
- Simultaneous edges on several channels in one cycle: all are captured, with identical coarse values.
- DONE holds results indefinitely.
- Readout: dout <= result[ch_sel][8*byte_sel +: 8] every cycle, in every state.
- ch_sel >= N_CH: dout <= 0.

## Timing
- Reset values: state IDLE, counter 0, results 0, dout 0x00, busy 0, done 0, timeout 0. Sync/pipeline flops are also 0.
- start at cycle t -> busy=1 at t+1, counter=0 at t+1.
- Stop latency: stop rising before clock edge k -> done[c]=1 after edge k+3, i.e. 3 clk of synchroniser plus edge detect. This 3-cycle offset is a constant and is not subtracted from the captured coarse value.
- Coarse quantisation is 1 clk; resolution below that comes from fine.
- Transition to DONE takes effect on the cycle after the last capture; busy drops there.
- dout latency: 1 cycle after a change of ch_sel, byte_sel or result.
- Reset asserted mid-RUN: everything returns to reset values immediately, regardless of clk.

## Test plan
- Reset check: assert rst_n high mid-RUN -> dout, busy, done and timeout all 0 with no clock edge; state IDLE after release.
- Single channel, N_CH=2, CNT_W=16:
  - Stimulus: start, then 10 cycles later raise stop[0] with taps ch0 = 0x0000FFFF.
  - Response: done=01; result[0] has coarse 12 and fine 16; reading byte_sel 0..3 returns the corresponding bytes of {coarse,fine} zero-extended.
- Both channels:
  - Stimulus: same-cycle stop edges with taps 0x000000FF and 0xFFFFFFFF.
  - Response: equal coarse values, fine 8 and 32; DONE entered one cycle after capture; busy falls.
- Bubble and repeat:
  - Stimulus: taps 0x0000F0FF on stop; then pulse the same stop twice more.
  - Response: fine 12; result unchanged by the second and third edges.
- Timeout:
  - Stimulus: CNT_W=4, start, no stops.
  - Response: after 16 RUN cycles, timeout=1, busy=0, done=00, results 0; start re-arms and clears timeout.
- Pre-high stop:
  - Stimulus: stop[1] held high before start; start; leave it high.
  - Response: no capture. A low-then-high pulse afterwards captures normally.
